// File: rtl/ppu_pkg.sv
// Shared pipeline constants for the fetch path: default word width,
// boot address, NOP encoding and the sequential PC increment.
package ppu_pkg;

  localparam int unsigned PPU_DATA_W      = 32;
  localparam logic [31:0] PPU_RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] PPU_NOP         = 32'h0100_0000;
  localparam logic [31:0] PPU_INSTR_BYTES = 32'd4;

  // Sequential successor of a fetch address; wraps modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PPU_INSTR_BYTES;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a single-cycle flush. Storage is cleared by the
// asynchronous reset so the head word reads zero until the first write.
// The head word is presented combinationally from storage (no bypass).
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_w, empty_w;
  logic             rd_fire, wr_fire;

  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign empty_w = (count_q == '0);

  // A read needs data; a write needs room unless a read frees a slot in the
  // same cycle. Flush wins over both.
  assign rd_fire = rd_en_i & ~empty_w & ~flush_i;
  assign wr_fire = wr_en_i & ~flush_i & (~full_w | rd_fire);

  // Next-state for pointers and occupancy; power-of-two depth wraps naturally.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (rd_fire) head_d = head_q + PTR_W'(1);
      if (wr_fire) tail_d = tail_q + PTR_W'(1);
      case ({wr_fire, rd_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage: cleared on reset, written at the tail on an accepted write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_fire) begin
      mem_q[tail_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[head_q];
  assign count_o   = count_q;
  assign full_o    = full_w;
  assign empty_o   = empty_w;

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(wr_en_i && !flush_i && full_w && !rd_fire));

  a_no_underflow : assert property (@(posedge clk) disable iff (rst)
    !(rd_en_i && !flush_i && empty_w));

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: drives a combinational instruction ROM from the
// fetch PC and buffers {instr, pc, pc+4} entries for decode. A redirect
// flushes every buffered entry and restarts fetch at the new address; the
// first redirected instruction becomes visible two cycles after the redirect
// edge (one cycle to fetch, one to appear at the head).
module fetch_queue
  import ppu_pkg::*;
#(
  parameter int unsigned DATA_W   = PPU_DATA_W,
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = PPU_RESET_PC
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [DATA_W-1:0]          imem_rdata,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [DATA_W-1:0]          deq_instr,
  output logic [31:0]                deq_pc,
  output logic [31:0]                deq_npc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned ENTRY_W = DATA_W + 64;

  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        fetch_npc;
  logic               enq, deq;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic               unused_fetch_pc;

  assign fetch_npc = next_pc(fetch_pc_q);
  assign imem_addr = fetch_pc_q[ADDR_W-1:0];
  // Upper fetch-PC bits only travel with the entry, not to the ROM.
  assign unused_fetch_pc = ^fetch_pc_q;

  // Head valid comes straight from occupancy, never from the incoming word.
  assign deq_valid = ~empty;
  assign deq       = deq_valid & deq_ready;
  assign enq       = ~redirect & (~full | deq);

  assign wr_entry = {imem_rdata, fetch_pc_q, fetch_npc};

  // Fetch PC: jump on redirect, advance on enqueue, otherwise hold (stall).
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end else if (enq) begin
      fetch_pc_d = fetch_npc;
    end
  end

  // Fetch PC register; reset dominates any concurrent redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .flush_i   (redirect),
    .wr_en_i   (enq),
    .wr_data_i (wr_entry),
    .rd_en_i   (deq),
    .rd_data_o (head_entry),
    .count_o   (count),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign deq_instr = head_entry[ENTRY_W-1 -: DATA_W];
  assign deq_pc    = head_entry[63:32];
  assign deq_npc   = head_entry[31:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios with literal expectations, then
// randomized redirect/stall/reset traffic checked every cycle against a
// queue-based behavioural model.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        deq_ready = 1'b0;
  logic        deq_valid;
  logic [31:0] deq_instr, deq_pc, deq_npc;
  logic [2:0]  count;
  logic        full, empty;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_queue #(
    .DATA_W   (32),
    .ADDR_W   (9),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .deq_ready   (deq_ready),
    .deq_valid   (deq_valid),
    .deq_instr   (deq_instr),
    .deq_pc      (deq_pc),
    .deq_npc     (deq_npc),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  // ROM[i] = i
  assign imem_rdata = 32'(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc = '0;
  bit          m_zero = 1'b1;

  always @(posedge clk or posedge reset) begin
    bit dq;
    int n;
    if (reset) begin
      m_q.delete();
      m_pc   = 32'h0;
      m_zero = 1'b1;
    end else begin
      n  = m_q.size();
      dq = (n != 0) && deq_ready;
      if (redirect) begin
        m_q.delete();
        m_pc = redirect_pc;
      end else begin
        if (dq) void'(m_q.pop_front());
        if (n < DEPTH || dq) begin
          m_q.push_back('{32'(m_pc[8:0]), m_pc, m_pc + 32'd4});
          m_pc   = m_pc + 32'd4;
          m_zero = 1'b0;
        end
      end
    end
  end

  // Compare process: outputs are settled mid-cycle.
  always @(negedge clk) begin
    check("m_valid", 32'(deq_valid), 32'(m_q.size() != 0));
    check("m_count", 32'(count), 32'(m_q.size()));
    check("m_full",  32'(full),  32'(m_q.size() == DEPTH));
    check("m_empty", 32'(empty), 32'(m_q.size() == 0));
    check("m_addr",  32'(imem_addr), 32'(m_pc[8:0]));
    if (m_q.size() != 0) begin
      check("m_instr", deq_instr, m_q[0].instr);
      check("m_pc",    deq_pc,    m_q[0].pc);
      check("m_npc",   deq_npc,   m_q[0].npc);
    end else if (m_zero) begin
      check("m_instr0", deq_instr, 32'h0);
      check("m_pc0",    deq_pc,    32'h0);
      check("m_npc0",   deq_npc,   32'h0);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, 32'(deq_valid), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"},  32'(full),  32'd0);
    check({tag, "_instr"}, deq_instr, 32'h0);
    check({tag, "_pc"},    deq_pc,    32'h0);
    check({tag, "_npc"},   deq_npc,   32'h0);
  endtask

  initial begin
    int exp_cnt [6];
    exp_cnt = '{1, 2, 3, 4, 4, 4};

    // Reset state, with a redirect pending that must have no effect.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    step();
    step();
    check_zero_outputs("rst");
    check("rst_addr", 32'(imem_addr), 32'h0);

    // Release with decode always ready: one entry per cycle from pc 0.
    redirect  = 1'b0;
    deq_ready = 1'b1;
    reset     = 1'b0;
    check("rel_valid0", 32'(deq_valid), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      check("stream_valid", 32'(deq_valid), 32'd1);
      check("stream_pc",    deq_pc,    32'(4 * k));
      check("stream_npc",   deq_npc,   32'(4 * k + 4));
      check("stream_instr", deq_instr, 32'(4 * k));
    end

    // Stall: queue fills to DEPTH and fetch freezes.
    deq_ready = 1'b0;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check("stall_count", 32'(count), 32'(exp_cnt[k]));
      check("stall_addr",  32'(imem_addr), 32'(4 * (k < 4 ? k + 1 : 4)));
      check("stall_head",  deq_pc, 32'h0);
    end
    check("stall_full", 32'(full), 32'd1);

    // Full queue with a dequeue: enqueue and dequeue in the same cycle.
    deq_ready = 1'b1;
    step();
    check("fulldq_count", 32'(count), 32'd4);
    check("fulldq_head",  deq_pc, 32'h4);
    check("fulldq_addr",  32'(imem_addr), 32'd20);
    for (int k = 0; k < 3; k++) begin
      step();
      check("drain_pc", deq_pc, 32'(8 + 4 * k));
    end
    check("drain_instr16", deq_instr, 32'd16);

    // Build count=3 after a redirect, then redirect to 0x40 while dequeuing.
    deq_ready   = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    check("rd1_count", 32'(count), 32'd0);
    redirect = 1'b0;
    step();
    step();
    step();
    check("rd1_count3", 32'(count), 32'd3);
    check("rd1_head",   deq_pc, 32'h200);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0040;
    deq_ready   = 1'b1;
    step();
    check("rd2_count", 32'(count), 32'd0);
    check("rd2_valid", 32'(deq_valid), 32'd0);
    check("rd2_addr",  32'(imem_addr), 32'h40);
    redirect  = 1'b0;
    deq_ready = 1'b0;
    step();
    check("rd2_head_valid", 32'(deq_valid), 32'd1);
    check("rd2_head_pc",    deq_pc, 32'h40);
    check("rd2_head_instr", deq_instr, 32'h40);

    // Asynchronous reset mid-cycle at count=2.
    @(posedge clk);
    #2;
    check("arst_pre_count", 32'(count), 32'd2);
    reset = 1'b1;
    #1;
    check_zero_outputs("arst");
    check("arst_addr", 32'(imem_addr), 32'h0);
    step();
    reset     = 1'b0;
    deq_ready = 1'b1;
    check("arst_rel_valid", 32'(deq_valid), 32'd0);
    step();
    check("arst_first_valid", 32'(deq_valid), 32'd1);
    check("arst_first_pc",    deq_pc, 32'h0);

    // PC wrap at 2^32.
    deq_ready   = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    check("wrap_addr", 32'(imem_addr), 32'h1FC);
    step();
    check("wrap_pc0",    deq_pc,    32'hFFFF_FFFC);
    check("wrap_npc0",   deq_npc,   32'h0);
    check("wrap_instr0", deq_instr, 32'h1FC);
    step();
    check("wrap_count", 32'(count), 32'd2);
    deq_ready = 1'b1;
    step();
    check("wrap_pc1",  deq_pc,  32'h0);
    check("wrap_npc1", deq_npc, 32'h4);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      step();
      deq_ready = ($urandom_range(0, 3) != 0) ^ (c[8] & ($urandom_range(0, 1) == 1));
      redirect  = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc = 32'hFFFF_FFF4;
        default: redirect_pc = $urandom & 32'hFFFF_FFFC;
      endcase
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        #1;
        reset = 1'b0;
      end
    end
    redirect  = 1'b0;
    deq_ready = 1'b0;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width.
REQ-002 SHALL have parameter ADDR_W, default 9, instruction-memory address width.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries; power of two, >=2.
REQ-004 SHALL have parameter RESET_PC, default 32'h0, first fetch address.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port imem_addr  output  ADDR_W  = fetch_pc[ADDR_W-1:0] to combinational ROM.
REQ-008 SHALL have port imem_rdata  input  DATA_W  ROM word for imem_addr, same cycle.
REQ-009 SHALL have port redirect  input  1  taken branch/call/jmpl; flush queue and refetch.
REQ-010 SHALL have port redirect_pc  input  32  new fetch address.
REQ-011 SHALL have port deq_ready  input  1  decode accepts head (driven as ~stall_D).
REQ-012 SHALL have port deq_valid  output  1  head entry valid.
REQ-013 SHALL have port deq_instr  output  DATA_W  head instruction.
REQ-014 SHALL have port deq_pc  output  32  head PC.
REQ-015 SHALL have port deq_npc  output  32  head PC+4.
REQ-016 SHALL have port count  output  $clog2(DEPTH+1)  occupied entries.
REQ-017 SHALL have ports full, empty  output  1 each  count==DEPTH, count==0.

Function
REQ-018 SHALL hold fetch_pc register; each entry stores {instr, pc, pc+4}.
REQ-019 SHALL define deq = deq_valid & deq_ready; deq_valid = (count!=0), combinational from storage only (no empty bypass).
REQ-020 SHALL define enq = ~redirect & (~full | deq); on enq write {imem_rdata, fetch_pc, fetch_pc+4} at tail, fetch_pc += 4.
REQ-021 SHALL leave fetch_pc and tail unchanged when no enq and no redirect (stall).
REQ-022 SHALL, on simultaneous enq and deq, keep count unchanged, advance both pointers.
REQ-023 SHALL wrap head/tail pointers modulo DEPTH; fetch_pc and pc+4 wrap modulo 2^32.
REQ-024 SHALL, on redirect, set count=0, head=tail=0, fetch_pc=redirect_pc next cycle; no enqueue that cycle.
REQ-025 SHALL treat deq asserted in a redirect cycle as completed; entry discarded with the rest.
REQ-026 SHALL present first redirected instruction with deq_valid=1 exactly 2 cycles after redirect edge (fetch cycle, then visible).
REQ-027 SHALL keep deq_instr/pc/npc stable while deq_valid=1 and deq_ready=0.
REQ-028 SHALL never overflow (enq blocked at full without deq) nor underflow (deq requires deq_valid).

Reset
REQ-029 SHALL, while reset=1, asynchronously force fetch_pc=RESET_PC, head=tail=0, count=0, deq_valid=0, empty=1, full=0.
REQ-030 SHALL clear storage on reset so deq_instr/deq_pc/deq_npc read 0.
REQ-031 SHALL discard all in-flight entries on reset mid-operation; first entry after release is RESET_PC.
REQ-032 SHALL give redirect no effect while reset=1.

Structure
REQ-033 SHALL take DATA_W default, RESET_PC and NOP encoding 32'h0100_0000 from shared package ppu_pkg.
REQ-034 SHALL implement storage in one sub-module sync_fifo (parametric width/depth, flush input); PC logic in fetch_queue.

Verification
REQ-035 SHALL cover reset release, deq_ready=1, ROM[i]=i: cycle 1 deq_valid=0; then deq_pc 0,4,8,... one per cycle, deq_npc=deq_pc+4.
REQ-036 SHALL cover deq_ready=0 for 6 cycles: count 1,2,3,4,4,4; full=1; imem_addr frozen at 16; head stays pc 0.
REQ-037 SHALL cover full queue with deq_ready=1 one cycle: count stays 4, head pc 0->4, new tail pc 16.
REQ-038 SHALL cover redirect=1, redirect_pc=0x40 with count=3: next cycle count=0, imem_addr=0x40; following cycle deq_pc=0x40.
REQ-039 SHALL cover reset asserted asynchronously mid-cycle at count=2: outputs zero immediately; after release deq_pc=0.
REQ-040 SHALL cover redirect_pc=0xFFFF_FFFC: entries pc 0xFFFF_FFFC then 0x0, deq_npc of first = 0x0.
